// File: rtl/md_pkg.sv
// Shared types for the multiply/divide sequencer: op encodings, FSM states, default latencies.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    StIdle,
    StRun
  } md_state_e;

  localparam int unsigned MD_MULT_LAT = 5;
  localparam int unsigned MD_DIV_LAT  = 10;
  localparam int unsigned MD_CNT_W    = 4;

  // Ops that occupy the unit for a multi-cycle latency.
  function automatic logic is_long_op(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// E-stage <-> multiply/divide unit signal bundle. The pipeline drives through master,
// md_ctrl receives through slave.
interface md_ctrl_if;
  import md_pkg::*;

  logic        start;
  md_op_e      md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        md_use_D;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_data, rt_data, md_use_D,
    input  busy, stall_md, hi, lo
  );

  modport slave (
    input  start, md_op, rs_data, rt_data, md_use_D,
    output busy, stall_md, hi, lo
  );

endinterface

// File: rtl/md_datapath.sv
// Combinational multiply/divide arithmetic. A zero divisor is replaced by 1 so the result is
// always defined; div_zero_o tells the controller to substitute or suppress the result.
module md_datapath
  import md_pkg::*;
(
  input  md_op_e      md_op_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o,
  output logic        div_zero_o
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] divisor;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;
  logic               div_ovf;

  assign prod_s  = $signed({{32{rs_data_i[31]}}, rs_data_i}) *
                   $signed({{32{rt_data_i[31]}}, rt_data_i});
  assign prod_u  = {32'd0, rs_data_i} * {32'd0, rt_data_i};
  assign divisor = (rt_data_i == 32'd0) ? 32'd1 : rt_data_i;
  assign quo_s   = $signed(rs_data_i) / $signed(divisor);
  assign rem_s   = $signed(rs_data_i) % $signed(divisor);
  assign quo_u   = rs_data_i / divisor;
  assign rem_u   = rs_data_i % divisor;
  // -2^31 / -1 overflows 32 bits; pin the wrapped result instead of trusting the operator.
  assign div_ovf = (rs_data_i == 32'h8000_0000) && (rt_data_i == 32'hFFFF_FFFF);

  assign div_zero_o = is_div_op(md_op_i) && (rt_data_i == 32'd0);

  always_comb begin
    res_hi_o = 32'd0;
    res_lo_o = 32'd0;
    case (md_op_i)
      MD_MULT:  {res_hi_o, res_lo_o} = prod_s;
      MD_MULTU: {res_hi_o, res_lo_o} = prod_u;
      MD_DIV: begin
        res_lo_o = div_ovf ? 32'h8000_0000 : quo_s;
        res_hi_o = div_ovf ? 32'd0 : rem_s;
      end
      MD_DIVU: begin
        res_lo_o = quo_u;
        res_hi_o = rem_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer and HI/LO owner. Define MD_DIV0_HOLD_EN to keep HI/LO unchanged
// on a divide by zero; otherwise it commits lo=all-ones, hi=dividend.
module md_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MULT_LAT = MD_MULT_LAT,
  parameter int unsigned DIV_LAT  = MD_DIV_LAT,
  parameter int unsigned CNT_W    = MD_CNT_W
) (
  input logic       clk,
  input logic       reset_n,
  md_ctrl_if.slave  md
);

  md_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] shadow_hi_q, shadow_hi_d;
  logic [31:0] shadow_lo_q, shadow_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_zero;

  md_datapath u_datapath (
    .md_op_i    (md.md_op),
    .rs_data_i  (md.rs_data),
    .rt_data_i  (md.rt_data),
    .res_hi_o   (res_hi),
    .res_lo_o   (res_lo),
    .div_zero_o (div_zero)
  );

`ifdef MD_DIV0_HOLD_EN
  // Set when the running op is a divide by zero; its commit is dropped.
  logic skip_q, skip_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skip_q <= 1'b0;
    end else begin
      skip_q <= skip_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    shadow_hi_d = shadow_hi_q;
    shadow_lo_d = shadow_lo_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
`ifdef MD_DIV0_HOLD_EN
    skip_d      = skip_q;
`endif
    case (state_q)
      StIdle: begin
        if (md.start) begin
          if (is_long_op(md.md_op)) begin
            state_d = StRun;
            busy_d  = 1'b1;
            cnt_d   = is_div_op(md.md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
`ifdef MD_DIV0_HOLD_EN
            shadow_hi_d = res_hi;
            shadow_lo_d = res_lo;
            skip_d      = div_zero;
`else
            shadow_hi_d = div_zero ? md.rs_data : res_hi;
            shadow_lo_d = div_zero ? 32'hFFFF_FFFF : res_lo;
`endif
          end else if (md.md_op == MD_MTHI) begin
            hi_d = md.rs_data;
          end else if (md.md_op == MD_MTLO) begin
            lo_d = md.rs_data;
          end
        end
      end
      StRun: begin
        // start is ignored here; the hazard unit holds md-class instrs in D while busy.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StIdle;
          busy_d  = 1'b0;
`ifdef MD_DIV0_HOLD_EN
          if (!skip_q) begin
            hi_d = shadow_hi_q;
            lo_d = shadow_lo_q;
          end
          skip_d = 1'b0;
`else
          hi_d = shadow_hi_q;
          lo_d = shadow_lo_q;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      shadow_hi_q <= 32'd0;
      shadow_lo_q <= 32'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      shadow_hi_q <= shadow_hi_d;
      shadow_lo_q <= shadow_lo_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign md.busy     = busy_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.stall_md = md.md_use_D & (busy_q | (md.start & is_long_op(md.md_op)));

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed scenarios plus randomized ops against a
// longint-arithmetic model of HI/LO. Honours MD_DIV0_HOLD_EN like the design.
module tb_md_ctrl;
  import md_pkg::*;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_ctrl_if mif ();

  md_ctrl #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md      (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // start must never be presented while the unit is busy.
  always @(negedge clk) begin
    #1;
    if (reset_n && mif.start) begin
      n_cmp++;
      if (mif.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL start_while_busy: busy=%b required 0", mif.busy);
      end
    end
  end

  // Reference model: architectural effect of one op on HI/LO.
  function automatic void model_op(input md_op_e op, input logic [31:0] rs,
                                   input logic [31:0] rt);
    longint sp;
    longint a;
    longint b;
    logic [63:0] up;
    case (op)
      MD_MULT: begin
        sp = longint'($signed(rs)) * longint'($signed(rt));
        m_hi = sp[63:32];
        m_lo = sp[31:0];
      end
      MD_MULTU: begin
        up = {32'd0, rs} * {32'd0, rt};
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      MD_DIV, MD_DIVU: begin
        if (rt == 32'd0) begin
`ifndef MD_DIV0_HOLD_EN
          m_lo = 32'hFFFF_FFFF;
          m_hi = rs;
`endif
        end else if (op == MD_DIV) begin
          a = longint'($signed(rs));
          b = longint'($signed(rt));
          sp = a / b;
          m_lo = sp[31:0];
          sp = a % b;
          m_hi = sp[31:0];
        end else begin
          m_lo = rs / rt;
          m_hi = rs % rt;
        end
      end
      MD_MTHI: m_hi = rs;
      MD_MTLO: m_lo = rs;
      default: ;
    endcase
  endfunction

  // Call at a negedge with the unit idle; returns at the negedge where busy is low again.
  task automatic issue_long(input md_op_e op, input logic [31:0] rs, input logic [31:0] rt,
                            output int bcyc);
    mif.start = 1'b1;
    mif.md_op = op;
    mif.rs_data = rs;
    mif.rt_data = rt;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    mif.md_op = MD_NONE;
    bcyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mif.busy === 1'b1) bcyc++;
      else break;
    end
  endtask

  task automatic issue_short(input md_op_e op, input logic [31:0] rs);
    mif.start = 1'b1;
    mif.md_op = op;
    mif.rs_data = rs;
    mif.rt_data = $urandom;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    mif.md_op = MD_NONE;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mif.start = 1'b0;
    mif.md_op = MD_NONE;
    mif.rs_data = 32'd0;
    mif.rt_data = 32'd0;
    mif.md_use_D = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp += 4;
    if (mif.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", mif.busy); end
    if (mif.hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", mif.hi); end
    if (mif.lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", mif.lo); end
    if (mif.stall_md !== 1'b0) begin
      n_bad++; $display("FAIL reset_stall: got %b want 0", mif.stall_md);
    end
    mif.md_use_D = 1'b0;
  endtask

  task automatic test_mult();
    int b;
    issue_long(MD_MULT, 32'd3, 32'hFFFF_FFFC, b);
    n_cmp += 3;
    if (b != 5) begin n_bad++; $display("FAIL mult_busy: got %0d want 5", b); end
    if (mif.hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi: got %h want ffffffff", mif.hi); end
    if (mif.lo !== 32'hFFFF_FFF4) begin n_bad++; $display("FAIL mult_lo: got %h want fffffff4", mif.lo); end
    issue_long(MD_MULTU, 32'hFFFF_FFFF, 32'd2, b);
    n_cmp += 3;
    if (b != 5) begin n_bad++; $display("FAIL multu_busy: got %0d want 5", b); end
    if (mif.hi !== 32'h1) begin n_bad++; $display("FAIL multu_hi: got %h want 00000001", mif.hi); end
    if (mif.lo !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_lo: got %h want fffffffe", mif.lo); end
    m_hi = 32'h1;
    m_lo = 32'hFFFF_FFFE;
  endtask

  task automatic test_div();
    int b;
    issue_long(MD_DIV, 32'hFFFF_FFF9, 32'd2, b);
    n_cmp += 3;
    if (b != 10) begin n_bad++; $display("FAIL div_busy: got %0d want 10", b); end
    if (mif.lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo: got %h want fffffffd", mif.lo); end
    if (mif.hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi: got %h want ffffffff", mif.hi); end
    issue_long(MD_DIVU, 32'd7, 32'd2, b);
    n_cmp += 3;
    if (b != 10) begin n_bad++; $display("FAIL divu_busy: got %0d want 10", b); end
    if (mif.lo !== 32'd3) begin n_bad++; $display("FAIL divu_lo: got %h want 3", mif.lo); end
    if (mif.hi !== 32'd1) begin n_bad++; $display("FAIL divu_hi: got %h want 1", mif.hi); end
    m_hi = 32'd1;
    m_lo = 32'd3;
  endtask

  task automatic test_stall_mthi();
    int stall_cyc;
    mif.md_use_D = 1'b1;
    mif.start = 1'b1;
    mif.md_op = MD_MULT;
    mif.rs_data = 32'd6;
    mif.rt_data = 32'd7;
    #1;
    n_cmp++;
    if (mif.stall_md !== 1'b1) begin
      n_bad++; $display("FAIL stall_start_cycle: got %b want 1", mif.stall_md);
    end
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    mif.md_op = MD_NONE;
    stall_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mif.busy !== 1'b1) break;
      if (mif.stall_md === 1'b1) stall_cyc++;
    end
    n_cmp += 2;
    if (stall_cyc != MULT_LAT) begin
      n_bad++; $display("FAIL stall_while_busy: got %0d cycles want %0d", stall_cyc, MULT_LAT);
    end
    if (mif.stall_md !== 1'b0) begin
      n_bad++; $display("FAIL stall_after_busy: got %b want 0", mif.stall_md);
    end
    model_op(MD_MULT, 32'd6, 32'd7);
    mif.md_use_D = 1'b0;
    mif.start = 1'b1;
    mif.md_op = MD_MULTU;
    #1;
    n_cmp++;
    if (mif.stall_md !== 1'b0) begin
      n_bad++; $display("FAIL stall_no_use: got %b want 0", mif.stall_md);
    end
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    mif.md_op = MD_NONE;
    @(negedge clk);
    n_cmp++;
    if (mif.stall_md !== 1'b0 || mif.busy !== 1'b1) begin
      n_bad++; $display("FAIL stall_busy_no_use: stall=%b busy=%b want 0/1", mif.stall_md, mif.busy);
    end
    for (int i = 0; i < 20 && mif.busy === 1'b1; i++) @(negedge clk);
    model_op(MD_MULTU, mif.rs_data, mif.rt_data);
    issue_short(MD_MTHI, 32'h1234);
    model_op(MD_MTHI, 32'h1234, 32'd0);
    n_cmp += 3;
    if (mif.hi !== 32'h1234) begin n_bad++; $display("FAIL mthi_hi: got %h want 00001234", mif.hi); end
    if (mif.lo !== m_lo) begin n_bad++; $display("FAIL mthi_lo: got %h want %h", mif.lo, m_lo); end
    if (mif.busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy: got %b want 0", mif.busy); end
  endtask

  task automatic test_reset_mid_op();
    int b;
    issue_short(MD_MTHI, 32'h5555_AAAA);
    issue_short(MD_MTLO, 32'h0F0F_0F0F);
    mif.start = 1'b1;
    mif.md_op = MD_DIV;
    mif.rs_data = 32'd100;
    mif.rt_data = 32'd3;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    mif.md_op = MD_NONE;
    repeat (4) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp += 3;
    if (mif.busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", mif.busy); end
    if (mif.hi !== 32'd0) begin n_bad++; $display("FAIL rst_mid_hi: got %h want 0", mif.hi); end
    if (mif.lo !== 32'd0) begin n_bad++; $display("FAIL rst_mid_lo: got %h want 0", mif.lo); end
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (mif.busy !== 1'b0 || mif.hi !== 32'd0) begin
      n_bad++; $display("FAIL rst_mid_idle: busy=%b hi=%h want 0/0", mif.busy, mif.hi);
    end
    issue_long(MD_MULT, 32'hFFFF_FF00, 32'd1000, b);
    model_op(MD_MULT, 32'hFFFF_FF00, 32'd1000);
    n_cmp += 3;
    if (b != MULT_LAT) begin n_bad++; $display("FAIL rst_mult_busy: got %0d want %0d", b, MULT_LAT); end
    if (mif.hi !== m_hi) begin n_bad++; $display("FAIL rst_mult_hi: got %h want %h", mif.hi, m_hi); end
    if (mif.lo !== m_lo) begin n_bad++; $display("FAIL rst_mult_lo: got %h want %h", mif.lo, m_lo); end
  endtask

  task automatic test_div_zero();
    int b;
    issue_short(MD_MTHI, 32'hA);
    issue_short(MD_MTLO, 32'hB);
    issue_long(MD_DIV, 32'd9, 32'd0, b);
    n_cmp += 3;
    if (b != DIV_LAT) begin n_bad++; $display("FAIL div0_busy: got %0d want %0d", b, DIV_LAT); end
`ifdef MD_DIV0_HOLD_EN
    if (mif.hi !== 32'hA) begin n_bad++; $display("FAIL div0_hi: got %h want 0000000a", mif.hi); end
    if (mif.lo !== 32'hB) begin n_bad++; $display("FAIL div0_lo: got %h want 0000000b", mif.lo); end
    m_hi = 32'hA;
    m_lo = 32'hB;
`else
    if (mif.hi !== 32'd9) begin n_bad++; $display("FAIL div0_hi: got %h want 00000009", mif.hi); end
    if (mif.lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div0_lo: got %h want ffffffff", mif.lo); end
    m_hi = 32'd9;
    m_lo = 32'hFFFF_FFFF;
`endif
  endtask

  task automatic test_back_to_back();
    int b1;
    int b2;
    issue_long(MD_MULT, 32'h8000_0000, 32'h8000_0000, b1);
    model_op(MD_MULT, 32'h8000_0000, 32'h8000_0000);
    n_cmp += 3;
    if (b1 != MULT_LAT) begin n_bad++; $display("FAIL b2b_mult_busy: got %0d want %0d", b1, MULT_LAT); end
    if (mif.hi !== m_hi) begin n_bad++; $display("FAIL b2b_mult_hi: got %h want %h", mif.hi, m_hi); end
    if (mif.lo !== m_lo) begin n_bad++; $display("FAIL b2b_mult_lo: got %h want %h", mif.lo, m_lo); end
    issue_long(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, b2);
    model_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    n_cmp += 3;
    if (b2 != DIV_LAT) begin n_bad++; $display("FAIL b2b_div_busy: got %0d want %0d", b2, DIV_LAT); end
    if (mif.hi !== m_hi) begin n_bad++; $display("FAIL b2b_div_hi: got %h want %h", mif.hi, m_hi); end
    if (mif.lo !== m_lo) begin n_bad++; $display("FAIL b2b_div_lo: got %h want %h", mif.lo, m_lo); end
  endtask

  task automatic test_random();
    md_op_e op;
    logic [31:0] rs;
    logic [31:0] rt;
    int b;
    int want_b;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 11))
        0, 1, 11: op = MD_MULT;
        2, 3:     op = MD_MULTU;
        4, 5:     op = MD_DIV;
        6, 7:     op = MD_DIVU;
        8:        op = MD_MTHI;
        9:        op = MD_MTLO;
        default:  op = MD_NONE;
      endcase
      rs = $urandom;
      rt = $urandom;
      if ($urandom_range(0, 3) == 0) rt = $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) rt = 32'd0;
      if (op == MD_DIV && $urandom_range(0, 9) == 0) begin
        rs = 32'h8000_0000;
        rt = 32'hFFFF_FFFF;
      end
      if (is_long_op(op)) begin
        issue_long(op, rs, rt, b);
        want_b = is_div_op(op) ? DIV_LAT : MULT_LAT;
        n_cmp++;
        if (b != want_b) begin
          n_bad++; $display("FAIL rnd_busy[%0d] op=%0d: got %0d want %0d", n, op, b, want_b);
        end
      end else begin
        issue_short(op, rs);
        n_cmp++;
        if (mif.busy !== 1'b0) begin
          n_bad++; $display("FAIL rnd_busy[%0d] op=%0d: got %b want 0", n, op, mif.busy);
        end
      end
      model_op(op, rs, rt);
      n_cmp += 2;
      if (mif.hi !== m_hi) begin
        n_bad++; $display("FAIL rnd_hi[%0d] op=%0d rs=%h rt=%h: got %h want %h",
                          n, op, rs, rt, mif.hi, m_hi);
      end
      if (mif.lo !== m_lo) begin
        n_bad++; $display("FAIL rnd_lo[%0d] op=%0d rs=%h rt=%h: got %h want %h",
                          n, op, rs, rt, mif.lo, m_lo);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_mult();
    test_div();
    test_stall_mthi();
    test_reset_mid_op();
    test_div_zero();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
